// File: rtl/hgc_pkg.sv
// hgc_pkg: shared definitions for the HGC VRAM sequencer slice.
//   Slot positions within a character period and the default period lengths.
//   Display mode enum and the fetch address builder used by the sequencer.
package hgc_pkg;

  localparam int unsigned SLOT_CHAR = 0;
  localparam int unsigned SLOT_ATT  = 4;
  localparam int unsigned SLOT_ROM  = 8;
  localparam int unsigned SLOT_CPU  = 10;

  localparam int unsigned TEXT_CLKS_DFLT = 18;
  localparam int unsigned GRPH_CLKS_DFLT = 16;

  typedef enum logic {
    MODE_TEXT = 1'b0,
    MODE_GRPH = 1'b1
  } mode_e;

  // Byte address of fetch byte b. Upper bits fall off with no carry.
  function automatic logic [15:0] fetch_addr(input mode_e      mode,
                                             input logic       page,
                                             input logic [1:0] row,
                                             input logic [11:0] ma,
                                             input logic       b);
    if (mode == MODE_GRPH) fetch_addr = {page, row, ma, b};
    else                   fetch_addr = {3'b000, ma, b};
  endfunction

endpackage

// File: rtl/hgc_cpu_port.sv
// hgc_cpu_port: CPU (ISA) side of the VRAM sequencer.
//   Latches a request while idle, offers it to the sequencer's CPU slot,
//   and produces the 1-clk ack plus read data.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   slot_start, slot_end         strobes: next cycle is CPU slot start / end
//   cpu_req/we/addr/wdata        CPU request, held until cpu_ack
//   vram_din                     SRAM read data
//   slot_hit/we/addr/wdata       request offered to the slot (incl. bypass)
//   cpu_rdata, cpu_ack           read data and completion pulse
module hgc_cpu_port (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        slot_start,
  input  logic        slot_end,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  vram_din,
  output logic        slot_hit,
  output logic        slot_we,
  output logic [15:0] slot_addr,
  output logic [7:0]  slot_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack
);

  logic        pending_q, pending_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        active_q, active_d;
  logic        ack_q, ack_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rd_done;

  always_comb begin
    // A request arriving in the cycle before the slot starts is offered
    // directly so that anything seen up to seq 9 is served this period.
    slot_hit   = pending_q | cpu_req;
    slot_we    = pending_q ? we_q    : cpu_we;
    slot_addr  = pending_q ? addr_q  : cpu_addr;
    slot_wdata = pending_q ? wdata_q : cpu_wdata;

    pending_d = pending_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    active_d  = active_q;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;

    if (!pending_q && cpu_req) begin
      pending_d = 1'b1;
      we_d      = cpu_we;
      addr_d    = cpu_addr;
      wdata_d   = cpu_wdata;
    end
    // Pending stays set through the ack cycle so a still-held req is not
    // latched again as a new request.
    if (ack_q) pending_d = 1'b0;

    if (slot_start) active_d = slot_hit;
    if (slot_end) begin
      ack_d    = active_q;
      active_d = 1'b0;
    end

    rd_done = ack_q & ~we_q;
    if (rd_done) rdata_d = vram_din;

    // SRAM data is only valid during the ack cycle, so it is passed through
    // then and held from the register afterwards.
    cpu_rdata = rd_done ? vram_din : rdata_q;
    cpu_ack   = ack_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      active_q  <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      pending_q <= pending_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      active_q  <= active_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: rtl/hgc_vram_sequencer.sv
// hgc_vram_sequencer: character-period sequencer for the HGC pixel pipeline.
//   Generates VRAM fetch addresses and strobes per character period and
//   interleaves one CPU access slot per period via hgc_cpu_port.
// Ports:
//   clk, reset_n            pixel clock, async active-low reset
//   grph_mode, gfx_page     mode / graphics page (mode sampled on wrap)
//   crtc_ma, row_addr       CRTC address inputs (registered at seq 0)
//   vram_din                SRAM read data
//   vram_addr/we/dout       SRAM address, write strobe, write data
//   clk_seq                 position within the character period
//   vram_read_char/att, charrom_read, disp_pipeline, crtc_clk: 1-clk strobes
//   cpu_req/we/addr/wdata   CPU request; cpu_rdata/cpu_ack completion
module hgc_vram_sequencer #(
  parameter int unsigned RAM_LAT   = 2,
  parameter int unsigned TEXT_CLKS = hgc_pkg::TEXT_CLKS_DFLT,
  parameter int unsigned GRPH_CLKS = hgc_pkg::GRPH_CLKS_DFLT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        grph_mode,
  input  logic        gfx_page,
  input  logic [11:0] crtc_ma,
  input  logic [4:0]  row_addr,
  input  logic [7:0]  vram_din,
  output logic [15:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_dout,
  output logic [4:0]  clk_seq,
  output logic        vram_read_char,
  output logic        vram_read_att,
  output logic        charrom_read,
  output logic        disp_pipeline,
  output logic        crtc_clk,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack
);
  import hgc_pkg::*;

  localparam logic [4:0] TEXT_LAST    = 5'(TEXT_CLKS - 1);
  localparam logic [4:0] GRPH_LAST    = 5'(GRPH_CLKS - 1);
  localparam logic [4:0] SEQ_CHAR     = 5'(SLOT_CHAR);
  localparam logic [4:0] SEQ_CHAR_RD  = 5'(SLOT_CHAR + RAM_LAT);
  localparam logic [4:0] SEQ_ATT      = 5'(SLOT_ATT);
  localparam logic [4:0] SEQ_ATT_RD   = 5'(SLOT_ATT + RAM_LAT);
  localparam logic [4:0] SEQ_ROM      = 5'(SLOT_ROM);
  localparam logic [4:0] SEQ_CPU      = 5'(SLOT_CPU);
  localparam logic [4:0] SEQ_CPU_END  = 5'(SLOT_CPU + RAM_LAT);

  logic [4:0]  seq_q, seq_d;
  mode_e       mode_q, mode_d;
  logic [11:0] ma_q, ma_d;
  logic [1:0]  row_q, row_d;
  logic        page_q, page_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  dout_q, dout_d;
  logic        rd_char_q, rd_char_d;
  logic        rd_att_q, rd_att_d;
  logic        rom_q, rom_d;
  logic        disp_q, disp_d;

  logic [4:0]  last_q, last_d;
  logic        wrap;
  logic        slot_start, slot_end;
  logic        slot_hit, slot_we;
  logic [15:0] slot_addr;
  logic [7:0]  slot_wdata;
  logic        unused_row;

  assign unused_row = ^row_addr[4:2];

  // All outputs are registered against seq_d so they line up with clk_seq.
  always_comb begin
    last_q = (mode_q == MODE_GRPH) ? GRPH_LAST : TEXT_LAST;
    wrap   = (seq_q == last_q);
    seq_d  = wrap ? '0 : seq_q + 5'd1;
    mode_d = wrap ? mode_e'(grph_mode) : mode_q;
    last_d = (mode_d == MODE_GRPH) ? GRPH_LAST : TEXT_LAST;

    slot_start = (seq_d == SEQ_CPU);
    slot_end   = (seq_d == SEQ_CPU_END);

    ma_d   = ma_q;
    row_d  = row_q;
    page_d = page_q;
    addr_d = addr_q;
    we_d   = 1'b0;
    dout_d = dout_q;

    if (seq_d == SEQ_CHAR) begin
      ma_d   = crtc_ma;
      row_d  = row_addr[1:0];
      page_d = gfx_page;
      addr_d = fetch_addr(mode_d, gfx_page, row_addr[1:0], crtc_ma, 1'b0);
    end
    if (seq_d == SEQ_ATT) addr_d = fetch_addr(mode_d, page_q, row_q, ma_q, 1'b1);
    if (slot_start && slot_hit) begin
      addr_d = slot_addr;
      we_d   = slot_we;
      dout_d = slot_wdata;
    end

    rd_char_d = (seq_d == SEQ_CHAR_RD);
    rd_att_d  = (seq_d == SEQ_ATT_RD);
    rom_d     = (seq_d == SEQ_ROM) && (mode_d == MODE_TEXT);
    disp_d    = (seq_d == last_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_q     <= '0;
      mode_q    <= MODE_TEXT;
      ma_q      <= '0;
      row_q     <= '0;
      page_q    <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      dout_q    <= '0;
      rd_char_q <= 1'b0;
      rd_att_q  <= 1'b0;
      rom_q     <= 1'b0;
      disp_q    <= 1'b0;
    end else begin
      seq_q     <= seq_d;
      mode_q    <= mode_d;
      ma_q      <= ma_d;
      row_q     <= row_d;
      page_q    <= page_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      dout_q    <= dout_d;
      rd_char_q <= rd_char_d;
      rd_att_q  <= rd_att_d;
      rom_q     <= rom_d;
      disp_q    <= disp_d;
    end
  end

  hgc_cpu_port u_cpu_port (
    .clk        (clk),
    .reset_n    (reset_n),
    .slot_start (slot_start),
    .slot_end   (slot_end),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .vram_din   (vram_din),
    .slot_hit   (slot_hit),
    .slot_we    (slot_we),
    .slot_addr  (slot_addr),
    .slot_wdata (slot_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack)
  );

  assign clk_seq        = seq_q;
  assign vram_addr      = addr_q;
  assign vram_we        = we_q;
  assign vram_dout      = dout_q;
  assign vram_read_char = rd_char_q;
  assign vram_read_att  = rd_att_q;
  assign charrom_read   = rom_q;
  assign disp_pipeline  = disp_q;
  assign crtc_clk       = disp_q;

endmodule

// File: tb/tb_hgc_vram_sequencer.sv
// tb_hgc_vram_sequencer: directed self-checking bench for hgc_vram_sequencer.
//   Walks whole character periods seq by seq, checking strobes, addresses
//   and the CPU handshake against hand-computed values. The SRAM is a
//   RAM_LAT-deep pipeline returning addr[7:0]^addr[15:8]^0x5C.
module tb_hgc_vram_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        grph_mode, gfx_page;
  logic [11:0] crtc_ma;
  logic [4:0]  row_addr;
  logic [7:0]  vram_din;
  logic [15:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_dout;
  logic [4:0]  clk_seq;
  logic        vram_read_char, vram_read_att, charrom_read, disp_pipeline, crtc_clk;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ack;

  int n_tests = 0;
  int n_fail  = 0;
  int cur_s   = 0;
  int cyc     = 0;
  int req_cyc = 0;
  int ack_lat = 0;

  logic [7:0] pipe1 = '0;
  logic [7:0] pipe2 = '0;

  hgc_vram_sequencer #(.RAM_LAT(2), .TEXT_CLKS(18), .GRPH_CLKS(16)) dut (
    .clk(clk), .reset_n(reset_n), .grph_mode(grph_mode), .gfx_page(gfx_page),
    .crtc_ma(crtc_ma), .row_addr(row_addr), .vram_din(vram_din),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_dout(vram_dout),
    .clk_seq(clk_seq), .vram_read_char(vram_read_char),
    .vram_read_att(vram_read_att), .charrom_read(charrom_read),
    .disp_pipeline(disp_pipeline), .crtc_clk(crtc_clk),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sram_data(input logic [15:0] a);
    sram_data = a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    pipe1 <= sram_data(vram_addr);
    pipe2 <= pipe1;
  end
  assign vram_din = pipe2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (seq %0d): got 0x%0h expected 0x%0h", tag, cur_s, got, exp);
    end
  endtask

  task automatic set_mode(input bit gfx);
    grph_mode = gfx;
    gfx_page  = gfx;
    row_addr  = gfx ? 5'd3 : 5'd0;
    crtc_ma   = gfx ? 12'h005 : 12'h123;
  endtask

  // Waits (bounded) for clk_seq==0, optionally checking the bus stays quiet.
  task automatic sync_to_seq0(input bit quiet);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cur_s = clk_seq;
      if (quiet) begin
        check_eq("quiet_ack", cpu_ack, 1'b0);
        check_eq("quiet_we", vram_we, 1'b0);
      end
      if (clk_seq == 5'd0) return;
    end
    check_eq("sync_timeout", clk_seq, 0);
  endtask

  // Checks one period starting from the current seq-0 sample.
  task automatic run_period(input int plen, input int rom_s, input logic [15:0] a0,
                            input int tog, input bit tog_gfx,
                            input int req_at, input bit rq_we,
                            input logic [15:0] rq_addr, input logic [7:0] rq_wdata,
                            input int slot_addr, input int we_at, input int ack_at,
                            input logic [7:0] exp_rd, input int abort_at);
    logic [4:0]  exp_stb;
    logic [15:0] exp_slot;
    for (int s = 0; s < plen; s++) begin
      cur_s = s;
      if (s == abort_at) begin
        reset_n = 1'b0;
        cpu_req = 1'b0;
        return;
      end
      exp_stb = {s == 2, s == 6, s == rom_s, s == plen - 1, s == plen - 1};
      check_eq("clk_seq", clk_seq, s);
      check_eq("strobes", {vram_read_char, vram_read_att, charrom_read,
                           disp_pipeline, crtc_clk}, exp_stb);
      check_eq("vram_we", vram_we, s == we_at);
      check_eq("cpu_ack", cpu_ack, s == ack_at);
      if (s == 0) check_eq("addr_byte0", vram_addr, a0);
      if (s == 4) check_eq("addr_byte1", vram_addr, a0 + 16'd1);
      if (s >= 10 && s <= 12) begin
        exp_slot = (slot_addr < 0) ? a0 + 16'd1 : 16'(slot_addr);
        check_eq("addr_cpu_slot", vram_addr, exp_slot);
      end
      if (s == we_at) check_eq("vram_dout", vram_dout, rq_wdata);
      if (s == ack_at) begin
        check_eq("cpu_rdata", cpu_rdata, exp_rd);
        ack_lat = cyc - req_cyc;
        cpu_req = 1'b0;
      end
      if (ack_at >= 0 && s == ack_at + 1) check_eq("cpu_rdata_held", cpu_rdata, exp_rd);
      if (s == req_at) begin
        cpu_req   = 1'b1;
        cpu_we    = rq_we;
        cpu_addr  = rq_addr;
        cpu_wdata = rq_wdata;
        req_cyc   = cyc;
      end
      if (s == tog) set_mode(tog_gfx);
      @(negedge clk);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    set_mode(1'b0);

    repeat (2) @(negedge clk);
    check_eq("rst_seq", clk_seq, 0);
    check_eq("rst_strobes", {vram_read_char, vram_read_att, charrom_read,
                             disp_pipeline, crtc_clk}, 0);
    check_eq("rst_we", vram_we, 1'b0);
    check_eq("rst_addr", vram_addr, 16'h0000);
    check_eq("rst_ack", cpu_ack, 1'b0);
    check_eq("rst_rdata", cpu_rdata, 8'h00);
    reset_n = 1'b1;
    sync_to_seq0(1'b0);

    // Three plain text periods.
    for (int p = 0; p < 3; p++)
      run_period(18, 8, 16'h0246, -1, 1'b0, -1, 1'b0, 16'h0, 8'h0, -1, -1, -1, 8'h0, -1);
    // Switch to graphics at seq 5: this period stays 18 clocks.
    run_period(18, 8, 16'h0246, 5, 1'b1, -1, 1'b0, 16'h0, 8'h0, -1, -1, -1, 8'h0, -1);
    // Graphics period of 16, no charrom_read; switch back at seq 5.
    run_period(16, -1, 16'hE00A, 5, 1'b0, -1, 1'b0, 16'h0, 8'h0, -1, -1, -1, 8'h0, -1);
    // CPU write raised at seq 3: served at seq 10, ack at seq 12.
    run_period(18, 8, 16'h0246, -1, 1'b0, 3, 1'b1, 16'h1234, 8'hA5,
               32'h1234, 10, 12, 8'h00, -1);
    // CPU read raised at seq 11: waits for the next period.
    run_period(18, 8, 16'h0246, -1, 1'b0, 11, 1'b0, 16'h0456, 8'h00,
               -1, -1, -1, 8'h00, -1);
    run_period(18, 8, 16'h0246, -1, 1'b0, -1, 1'b0, 16'h0, 8'h0,
               32'h0456, -1, 12, 8'h0E, -1);
    cur_s = 12;
    check_eq("ack_latency", ack_lat, 19);

    // Write pending, reset at seq 11 before its ack.
    run_period(18, 8, 16'h0246, -1, 1'b0, 3, 1'b1, 16'h2222, 8'h3C,
               32'h2222, 10, -1, 8'h00, 11);
    #1;
    check_eq("abort_seq", clk_seq, 0);
    check_eq("abort_ack", cpu_ack, 1'b0);
    check_eq("abort_we", vram_we, 1'b0);
    check_eq("abort_addr", vram_addr, 16'h0000);
    check_eq("abort_rdata", cpu_rdata, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    sync_to_seq0(1'b1);
    run_period(18, 8, 16'h0246, -1, 1'b0, -1, 1'b0, 16'h0, 8'h0, -1, -1, -1, 8'h00, -1);
    // Re-request after reset: read served normally.
    run_period(18, 8, 16'h0246, -1, 1'b0, 2, 1'b0, 16'h2222, 8'h00,
               32'h2222, -1, 12, 8'h5C, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
